// File: rtl/polar_rx_framer.sv
// Receive-side framer for a polar decoder: deserializes 16-bit codewords, launches one decode
// at a time with a watchdog, and queues decoded bytes in a small FIFO for a valid/ready consumer.
module polar_rx_framer #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 512
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        bit_in,
    input  logic        bit_valid,
    output logic [15:0] dec_codeword,
    output logic        dec_start,
    input  logic [7:0]  dec_data,
    input  logic        dec_valid,
    input  logic        dec_corrected,
    output logic [7:0]  out_data,
    output logic        out_corrected,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        overflow_sticky,
    output logic        timeout_sticky,
    output logic [15:0] frame_count,
    output logic [15:0] corr_count
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t        state_q;
    logic [15:0]   shift_q;
    logic [3:0]    bitCnt_q;
    logic [15:0]   hold_q;
    logic          holdFull_q;
    logic          overflow_q;
    logic          timeout_q;
    logic [15:0]   codeword_q;
    logic          start_q;
    logic [15:0]   watchdog_q;
    logic [15:0]   frameCnt_q;
    logic [15:0]   corrCnt_q;
    logic [8:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wrPtr_q;
    logic [PW-1:0] rdPtr_q;
    logic [CW-1:0] fifoCount_q;

    logic [15:0]   word_d;
    logic          wordDone;
    logic          fifoFull;
    logic          launch;
    logic          holdLoad;
    logic          push;
    logic          pop;

    assign word_d   = {shift_q[14:0], bit_in};
    assign wordDone = bit_valid && (bitCnt_q == 4'd15);
    assign fifoFull = (fifoCount_q == CW'(FIFO_DEPTH));
    // A launch is only allowed when the FIFO has room, so the eventual push can never overflow it.
    assign launch   = (state_q == IDLE) && holdFull_q && !fifoFull;
    assign holdLoad = wordDone && (!holdFull_q || launch);
    assign push     = (state_q == WAIT) && dec_valid;
    assign pop      = (fifoCount_q != '0) && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q    <= '0;
            bitCnt_q   <= '0;
            hold_q     <= '0;
            holdFull_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (bit_valid) shift_q <= word_d;
            if (clear) begin
                bitCnt_q   <= '0;
                holdFull_q <= 1'b0;
                overflow_q <= 1'b0;
            end else begin
                if (bit_valid) bitCnt_q <= bitCnt_q + 4'd1;
                if (holdLoad) begin
                    hold_q     <= word_d;
                    holdFull_q <= 1'b1;
                end else if (launch) begin
                    holdFull_q <= 1'b0;
                end
                if (wordDone && !holdLoad) overflow_q <= 1'b1;
            end
        end
    end

    // The codeword register is only written on launch, so the decoder sees a stable input for the whole search.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            codeword_q <= '0;
            start_q    <= 1'b0;
            watchdog_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (launch) begin
                        codeword_q <= hold_q;
                        start_q    <= 1'b1;
                        watchdog_q <= '0;
                        state_q    <= WAIT;
                    end
                end
                WAIT: begin
                    if (dec_valid) begin
                        state_q <= IDLE;
                    end else if (watchdog_q == 16'(TIMEOUT - 1)) begin
                        if (!clear) timeout_q <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        watchdog_q <= watchdog_q + 16'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (clear) timeout_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            fifoCount_q <= '0;
            frameCnt_q  <= '0;
            corrCnt_q   <= '0;
        end else begin
            if (push) wrPtr_q <= wrPtr_q + PW'(1);
            if (pop)  rdPtr_q <= rdPtr_q + PW'(1);
            case ({push, pop})
                2'b10:   fifoCount_q <= fifoCount_q + CW'(1);
                2'b01:   fifoCount_q <= fifoCount_q - CW'(1);
                default: fifoCount_q <= fifoCount_q;
            endcase
            if (clear) begin
                frameCnt_q <= '0;
                corrCnt_q  <= '0;
            end else if (push) begin
                frameCnt_q <= frameCnt_q + 16'd1;
                if (dec_corrected && (corrCnt_q != 16'hFFFF)) corrCnt_q <= corrCnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wrPtr_q] <= {dec_corrected, dec_data};
    end

    // Storage is not reset, so the head is masked while empty to give clean zero outputs.
    assign out_valid                 = (fifoCount_q != '0);
    assign {out_corrected, out_data} = out_valid ? mem_q[rdPtr_q] : 9'd0;

    assign dec_codeword    = codeword_q;
    assign dec_start       = start_q;
    assign overflow_sticky = overflow_q;
    assign timeout_sticky  = timeout_q;
    assign frame_count     = frameCnt_q;
    assign corr_count      = corrCnt_q;

endmodule

// File: tb/tb_polar_rx_framer.sv
// Directed self-checking bench for polar_rx_framer; the decoder is modelled by directed
// dec_valid pulses issued from the single stimulus sequence.
module tb_polar_rx_framer;

    localparam int FIFO_DEPTH = 4;
    localparam int TIMEOUT    = 512;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        bitIn;
    logic        bitValid;
    logic [15:0] decCodeword;
    logic        decStart;
    logic [7:0]  decData;
    logic        decValid;
    logic        decCorrected;
    logic [7:0]  outData;
    logic        outCorrected;
    logic        outValid;
    logic        outReady;
    logic        overflowSticky;
    logic        timeoutSticky;
    logic [15:0] frameCount;
    logic [15:0] corrCount;

    int errors     = 0;
    int checks     = 0;
    int startCount = 0;
    int startBase;

    polar_rx_framer #(.FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .bit_in(bitIn), .bit_valid(bitValid),
        .dec_codeword(decCodeword), .dec_start(decStart),
        .dec_data(decData), .dec_valid(decValid), .dec_corrected(decCorrected),
        .out_data(outData), .out_corrected(outCorrected),
        .out_valid(outValid), .out_ready(outReady),
        .overflow_sticky(overflowSticky), .timeout_sticky(timeoutSticky),
        .frame_count(frameCount), .corr_count(corrCount)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (decStart === 1'b1) startCount++;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] word);
        for (int i = 15; i >= 0; i--) begin
            bitIn    = word[i];
            bitValid = 1'b1;
            tick();
        end
        bitValid = 1'b0;
        bitIn    = 1'b0;
    endtask

    task automatic decodeReply(input logic [7:0] data, input logic corr, input int delay);
        repeat (delay) tick();
        decData      = data;
        decCorrected = corr;
        decValid     = 1'b1;
        tick();
        decValid     = 1'b0;
        decCorrected = 1'b0;
        decData      = 8'h00;
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; bitIn = 1'b0; bitValid = 1'b0;
        decData = 8'h00; decValid = 1'b0; decCorrected = 1'b0; outReady = 1'b0;
        repeat (3) tick();
        checkOutput("rst dec_start", decStart, 1'b0);
        checkOutput("rst dec_codeword", decCodeword, 16'h0000);
        checkOutput("rst out_valid", outValid, 1'b0);
        checkOutput("rst out_data", outData, 8'h00);
        checkOutput("rst out_corrected", outCorrected, 1'b0);
        checkOutput("rst overflow", overflowSticky, 1'b0);
        checkOutput("rst timeout", timeoutSticky, 1'b0);
        checkOutput("rst frame_count", frameCount, 16'd0);
        checkOutput("rst corr_count", corrCount, 16'd0);
        rst_n = 1'b1;
        tick();

        // All-ones codeword, decoder answers after about 258 cycles.
        applyStimulus(16'hFFFF);
        checkOutput("s1 start latency1", decStart, 1'b0);
        tick();
        checkOutput("s1 start", decStart, 1'b1);
        checkOutput("s1 codeword", decCodeword, 16'hFFFF);
        tick();
        checkOutput("s1 start one pulse", decStart, 1'b0);
        repeat (250) tick();
        checkOutput("s1 codeword stable", decCodeword, 16'hFFFF);
        checkOutput("s1 not valid yet", outValid, 1'b0);
        decodeReply(8'h80, 1'b0, 5);
        checkOutput("s1 out_valid", outValid, 1'b1);
        checkOutput("s1 out_data", outData, 8'h80);
        checkOutput("s1 out_corrected", outCorrected, 1'b0);
        checkOutput("s1 frame_count", frameCount, 16'd1);
        checkOutput("s1 corr_count", corrCount, 16'd0);
        checkOutput("s1 start count", startCount, 1);
        outReady = 1'b1; tick(); outReady = 1'b0;
        checkOutput("s1 drained", outValid, 1'b0);

        // Single-bit error on the all-zero codeword, reported as corrected.
        applyStimulus(16'h0001);
        tick();
        checkOutput("s2 start", decStart, 1'b1);
        checkOutput("s2 codeword", decCodeword, 16'h0001);
        decodeReply(8'h00, 1'b1, 50);
        checkOutput("s2 out_valid", outValid, 1'b1);
        checkOutput("s2 out_data", outData, 8'h00);
        checkOutput("s2 out_corrected", outCorrected, 1'b1);
        checkOutput("s2 corr_count", corrCount, 16'd1);
        checkOutput("s2 frame_count", frameCount, 16'd2);
        outReady = 1'b1; tick(); outReady = 1'b0;

        // Three words back-to-back: first decodes, second waits in hold, third overflows.
        startBase = startCount;
        applyStimulus(16'hA5A5);
        applyStimulus(16'h3C3C);
        applyStimulus(16'h0F0F);
        checkOutput("s3 overflow", overflowSticky, 1'b1);
        checkOutput("s3 one launch", startCount, startBase + 1);
        checkOutput("s3 codeword A", decCodeword, 16'hA5A5);
        decodeReply(8'h11, 1'b0, 100);
        checkOutput("s3 first byte", outData, 8'h11);
        tick();
        checkOutput("s3 second start", decStart, 1'b1);
        checkOutput("s3 codeword B", decCodeword, 16'h3C3C);
        decodeReply(8'h22, 1'b0, 20);
        checkOutput("s3 launches", startCount, startBase + 2);
        checkOutput("s3 frame_count", frameCount, 16'd4);
        outReady = 1'b1;
        checkOutput("s3 head 1", outData, 8'h11);
        tick();
        checkOutput("s3 head 2", outData, 8'h22);
        tick();
        outReady = 1'b0;
        checkOutput("s3 drained", outValid, 1'b0);
        clear = 1'b1; tick(); clear = 1'b0;
        checkOutput("s3 clear overflow", overflowSticky, 1'b0);
        checkOutput("s3 clear frame", frameCount, 16'd0);
        checkOutput("s3 clear corr", corrCount, 16'd0);

        // Fill the FIFO with out_ready low, then one extra word that must wait in hold.
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            applyStimulus(16'(16'h1111 * (i + 1)));
            tick();
            checkOutput("s4 fill start", decStart, 1'b1);
            decodeReply(8'(8'h10 + i), 1'b0, 2);
        end
        checkOutput("s4 full valid", outValid, 1'b1);
        checkOutput("s4 full frame", frameCount, 16'(FIFO_DEPTH));
        startBase = startCount;
        applyStimulus(16'h5555);
        repeat (10) tick();
        checkOutput("s4 no launch full", startCount, startBase);
        checkOutput("s4 no overflow", overflowSticky, 1'b0);
        outReady = 1'b1;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            checkOutput("s4 drain order", outData, 8'(8'h10 + i));
            tick();
        end
        outReady = 1'b0;
        checkOutput("s4 drained", outValid, 1'b0);
        checkOutput("s4 pending launch", startCount, startBase + 1);
        checkOutput("s4 pending codeword", decCodeword, 16'h5555);
        decodeReply(8'h44, 1'b0, 3);
        checkOutput("s4 pending byte", outData, 8'h44);
        checkOutput("s4 frame", frameCount, 16'd5);
        outReady = 1'b1; tick(); outReady = 1'b0;

        // Decoder never answers: watchdog expires exactly TIMEOUT cycles after launch.
        applyStimulus(16'h7777);
        tick();
        checkOutput("s5 start", decStart, 1'b1);
        repeat (TIMEOUT - 1) tick();
        checkOutput("s5 timeout early", timeoutSticky, 1'b0);
        tick();
        checkOutput("s5 timeout", timeoutSticky, 1'b1);
        checkOutput("s5 frame unchanged", frameCount, 16'd5);
        decodeReply(8'h99, 1'b1, 1);
        checkOutput("s5 late valid ignored", outValid, 1'b0);
        checkOutput("s5 late frame", frameCount, 16'd5);
        checkOutput("s5 late corr", corrCount, 16'd0);
        clear = 1'b1; tick(); clear = 1'b0;
        checkOutput("s5 clear timeout", timeoutSticky, 1'b0);
        checkOutput("s5 clear frame", frameCount, 16'd0);

        // Reset while a decode is outstanding, with a byte already queued.
        applyStimulus(16'h0101);
        tick();
        decodeReply(8'h5A, 1'b0, 4);
        checkOutput("s6 queued", outValid, 1'b1);
        checkOutput("s6 frame", frameCount, 16'd1);
        applyStimulus(16'h0202);
        tick();
        checkOutput("s6 start", decStart, 1'b1);
        repeat (20) tick();
        rst_n = 1'b0;
        #1;
        checkOutput("s6 async out_valid", outValid, 1'b0);
        checkOutput("s6 async codeword", decCodeword, 16'h0000);
        tick();
        rst_n = 1'b1;
        tick();
        decodeReply(8'h66, 1'b1, 2);
        checkOutput("s6 no push", outValid, 1'b0);
        checkOutput("s6 out_data", outData, 8'h00);
        checkOutput("s6 out_corrected", outCorrected, 1'b0);
        checkOutput("s6 frame", frameCount, 16'd0);
        checkOutput("s6 corr", corrCount, 16'd0);
        checkOutput("s6 dec_start", decStart, 1'b0);
        checkOutput("s6 codeword", decCodeword, 16'h0000);
        checkOutput("s6 stickies", {overflowSticky, timeoutSticky}, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/polar_rx_framer.md
POLAR_RX_FRAMER -- requirements
Module: polar_rx_framer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, decoded-byte FIFO entries, power of two, 2..16.
REQ-002 Parameter TIMEOUT, default 512, max cycles to wait for decoder result, 300..65535.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 clear  input  1  synchronous clear of stickies, counters, bit framing.
REQ-006 bit_in / bit_valid  input  1 / 1  serial received codeword bit, MSB first; qualifier.
REQ-007 dec_codeword  output  16  codeword driven to the polar decoder's codeword_in.
REQ-008 dec_start  output  1  one-cycle decode request to the decoder's decode_en.
REQ-009 dec_data / dec_valid / dec_corrected  input  8 / 1 / 1  decoder data_out, valid_out, error_corrected.
REQ-010 out_data / out_corrected  output  8 / 1  FIFO head byte; its corrected flag.
REQ-011 out_valid / out_ready  output / input  1 / 1  downstream valid/ready handshake.
REQ-012 overflow_sticky / timeout_sticky  output  1 / 1  codeword dropped; decoder timed out.
REQ-013 frame_count / corr_count  output  16 / 16  bytes pushed to FIFO (wrapping); corrected bytes (saturating).

Function
REQ-014 Deserializer: each bit_valid cycle SHALL do shift={shift[14:0],bit_in}, bit counter 0..15 increments; 16th bit completes a word, counter wraps to 0.
REQ-015 Completed word SHALL load the hold register and set hold_full when hold is empty or is being consumed that same cycle; otherwise word discarded, overflow_sticky set.
REQ-016 Control FSM states IDLE, WAIT; reset state IDLE.
REQ-017 IDLE->WAIT when hold_full and (fifo_count + 1) <= FIFO_DEPTH: dec_codeword<=hold, dec_start<=1 for exactly one cycle, hold_full<=0, watchdog<=0.
REQ-018 dec_codeword SHALL stay unchanged from launch until WAIT exits (decoder searches ~258 cycles on it).
REQ-019 WAIT: dec_valid SHALL push {dec_corrected,dec_data} into FIFO, increment frame_count (wrap), increment corr_count if dec_corrected (saturate 0xFFFF), go IDLE.
REQ-020 WAIT: watchdog increments each cycle; reaching TIMEOUT without dec_valid SHALL set timeout_sticky, push nothing, go IDLE.
REQ-021 dec_valid outside WAIT SHALL be ignored (no push, no count change).
REQ-022 FIFO: out_valid = not empty; out_data/out_corrected = head entry; pop on out_valid && out_ready; push and pop in the same cycle SHALL both occur, count unchanged.
REQ-023 Launch gating in REQ-017 SHALL guarantee a push never hits a full FIFO; with FIFO full and out_ready low, framer stalls in IDLE, further words overflow per REQ-015.
REQ-024 clear SHALL zero overflow_sticky, timeout_sticky, frame_count, corr_count, bit counter and hold_full; FIFO contents and FSM state unaffected; clear wins over simultaneous set in the same cycle.
REQ-025 Minimum latency 16th bit -> dec_start high: 2 cycles (hold load, launch); dec_valid -> out_valid high: 1 cycle.

Reset
REQ-026 rst_n low SHALL asynchronously force: FSM IDLE, dec_start 0, dec_codeword 0x0000, hold_full 0, bit counter 0, FIFO empty, out_valid 0, out_data 0x00, out_corrected 0, both stickies 0, both counters 0.
REQ-027 Reset mid-WAIT SHALL abandon the decode; a later dec_valid after release is ignored per REQ-021.

Verification
REQ-028 Shift 16 bits of 0xFFFF, decoder model returns dec_data=0x80, dec_corrected=0 after 258 cycles -> one dec_start pulse with dec_codeword=0xFFFF, out_valid with out_data=0x80, frame_count=1, corr_count=0.
REQ-029 Shift 0x0001 (single error on 0x0000), model returns 0x00 corrected=1 -> out_data=0x00, out_corrected=1, corr_count=1.
REQ-030 Stream three codewords back-to-back (48 bit_valid cycles) while first decode in progress -> second held, third sets overflow_sticky; exactly two bytes emerge in order.
REQ-031 out_ready low, feed FIFO_DEPTH+1 words with fast decoder model -> FIFO_DEPTH bytes stored, no launch while full, out_ready high drains in order, pending hold word then launches.
REQ-032 Model never asserts dec_valid -> timeout_sticky=1 exactly TIMEOUT cycles after launch, FSM IDLE, frame_count unchanged; clear -> sticky 0.
REQ-033 Assert rst_n low during WAIT, then model asserts dec_valid after release -> no FIFO push, all outputs at reset values.
